led_status_reader: RTL and testbench
====================================

# led_status_reader

Polling read initiator for the LED peripheral register interface, the read-side counterpart of the ROM-driven write sequencer. It periodically issues two byte reads (LED low byte, LED high byte) to the peripheral. It assembles them into a 16-bit LED snapshot and reports each completed snapshot with a one-cycle valid pulse. Reads that get no response are bounded by a timeout, which is flagged as an error.

## Interface
- POLL_CYCLES, 64: idle cycles in WAIT_POLL between snapshots; legal range ≥1.
- TIMEOUT_CYCLES, 8: maximum WAIT cycles per read; legal range ≥1.
- LED_LO_ADDR, 8'h00: address of LED[7:0].
- LED_HI_ADDR, 8'h01: address of LED[15:8].

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; **one clock; reset is asynchronous and active-low (0 = reset)**.
- enable  in  1  polling enable (level).
- rd_en  out  1  read request strobe; one-cycle pulse.
- rd_addr  out  8  read address; valid while rd_en=1.
- rd_data  in  8  read data from the peripheral; sampled when rd_valid=1.
- rd_valid  in  1  read response strobe from the peripheral.
- snapshot  out  16  last complete LED value, {hi, lo}.
- snap_valid  out  1  one-cycle pulse when snapshot updates.
- timeout_err  out  1  sticky; set on any read timeout.
- busy  out  1  high in every state except IDLE.
- poll_count  out  32  number of completed snapshots.

## Operation
- States:
  - IDLE, REQ_LO, WAIT_LO, REQ_HI, WAIT_HI, UPDATE, WAIT_POLL.
- Transitions:
  - IDLE → REQ_LO when enable=1.
  - REQ_LO: rd_en=1, rd_addr=LED_LO_ADDR for exactly one cycle → WAIT_LO.
  - WAIT_LO: if rd_valid=1, capture rd_data into lo_byte → REQ_HI.
  - REQ_HI and WAIT_HI: same pattern with LED_HI_ADDR, capturing into hi_byte → UPDATE.
  - UPDATE: snapshot←{hi_byte, lo_byte}; snap_valid=1; poll_count+1, wrapping 2^32−1→0.
    - If enable=1 → WAIT_POLL; otherwise → IDLE.
  - WAIT_POLL: stays exactly POLL_CYCLES cycles, then → REQ_LO.
    - If enable=0 at any cycle → IDLE next cycle.
- Timeout:
  - A wait counter clears on entry to WAIT_LO/WAIT_HI and increments each cycle there without rd_valid.
  - When it reaches TIMEOUT_CYCLES, timeout_err←1 and the state goes → WAIT_POLL, or → IDLE if enable=0.
  - On timeout there is no snapshot update, no snap_valid and no poll_count change.
- rd_valid is ignored in every state other than WAIT_LO/WAIT_HI, including the REQ cycle itself.
- Dropping enable mid-transaction does not abort it; the transaction completes or times out first. Snapshots are atomic.
- timeout_err is cleared only by reset.

## Timing
- Reset values:
  - rd_en=0, rd_addr=0, snapshot=0, snap_valid=0, timeout_err=0, busy=0, poll_count=0.
  - State is IDLE.
- All outputs are registered.
- Start latency: enable sampled high in IDLE → rd_en high on the next cycle.
- Best case, with rd_valid on the first WAIT cycle: rd_en (lo) at cycle N, rd_en (hi) at N+2, snap_valid at N+4.
- Snapshot period with immediate responses: 5 + POLL_CYCLES cycles from one REQ_LO to the next.
- Timeout fires on the TIMEOUT_CYCLES-th WAIT cycle without rd_valid.
- Reset asserted mid-operation forces all outputs to their reset values immediately and asynchronously. After release, a new snapshot starts from REQ_LO.

## Configuration
- LED_READER_CHANGE_ONLY_EN defined:
  - In UPDATE, snap_valid pulses only if {hi, lo} differs from the current snapshot, or if this is the first snapshot since reset.
  - snapshot and poll_count update every time regardless.
- Undefined: snap_valid pulses on every UPDATE.

## Structure
- Shared package holds:
  - the state enum;
  - default LED_LO_ADDR/LED_HI_ADDR constants, shared with the write-side ROM and the peripheral.
- One sub-module, led_reader_timer:
  - a loadable down-counter used for both the WAIT_POLL interval and the read timeout;
  - terminal-count output.
- The FSM and datapath live in led_status_reader.

## Test plan
- **Basic snapshot:** reset; enable=1; responder returns 0x34 for 0x00 and 0x12 for 0x01, each 1 cycle after rd_en → rd_en at addr 0x00 then 0x01 two cycles apart; snap_valid 4 cycles after first rd_en; snapshot=0x1234; poll_count=1.
- **Poll interval:** POLL_CYCLES=4 with immediate responses → consecutive REQ_LO pulses exactly 9 cycles apart; poll_count=3 after the third snapshot.
- **Timeout:** TIMEOUT_CYCLES=8; no rd_valid for the hi read → timeout_err=1 on the 8th WAIT_HI cycle; snapshot and poll_count unchanged; next poll succeeds with timeout_err still 1.
- **Enable drop:** enable→0 during WAIT_LO → transaction completes; snap_valid pulses; state IDLE; busy=0; no further rd_en for 50 cycles.
- **Reset mid-read:** rst=0 during WAIT_HI → all outputs at reset values in the same cycle. After release with enable=1, rd_en at addr 0x00 one cycle later.
- **Change filter:** responder returns 0xBEEF twice, then 0xBEF0 → with LED_READER_CHANGE_ONLY_EN, 2 snap_valid pulses; without it, 3; poll_count=3 in both cases.

Source files
------------

// File: rtl/led_status_reader_pkg.sv
// Shared definitions for the LED status read initiator.
// Holds the reader state encoding and the default LED register addresses.
// The write-side ROM sequencer and the LED peripheral use the same addresses.
package led_status_reader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ_LO,
      ST_WAIT_LO,
      ST_REQ_HI,
      ST_WAIT_HI,
      ST_UPDATE,
      ST_WAIT_POLL
   } reader_state_t;

   localparam logic [7:0] LED_LO_ADDR_DEFAULT = 8'h00;
   localparam logic [7:0] LED_HI_ADDR_DEFAULT = 8'h01;

   localparam int TIMER_WIDTH = 32;

   // Builds a snapshot word from its two bytes, with the high byte first.
   function automatic logic [15:0] join_bytes(input logic [7:0] hi, input logic [7:0] lo);
      return {hi, lo};
   endfunction

endpackage

// File: rtl/led_reader_timer.sv
// Loadable down-counter that serves both the poll interval and the read timeout.
// tc is high whenever the count is zero. The count holds at zero rather than wrapping.
module led_reader_timer
   import led_status_reader_pkg::*;
#(
   parameter int WIDTH = TIMER_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec,
   output logic             tc
);

   logic [WIDTH-1:0] count;

   // Load takes priority over decrement. The count saturates at zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/led_status_reader.sv
// Polling read initiator for the LED peripheral.
// It reads the low byte and then the high byte, and publishes a 16-bit snapshot.
// Each published snapshot gets a one-cycle snap_valid pulse.
// Reads that get no response end after a bounded wait and set the sticky timeout_err.
// Optional build macro LED_READER_CHANGE_ONLY_EN:
// when it is defined, snap_valid pulses only when the value changes,
// or on the first snapshot after reset.
module led_status_reader
   import led_status_reader_pkg::*;
#(
   parameter int         POLL_CYCLES    = 64,
   parameter int         TIMEOUT_CYCLES = 8,
   parameter logic [7:0] LED_LO_ADDR    = LED_LO_ADDR_DEFAULT,
   parameter logic [7:0] LED_HI_ADDR    = LED_HI_ADDR_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   output logic        rd_en,
   output logic [7:0]  rd_addr,
   input  logic [7:0]  rd_data,
   input  logic        rd_valid,
   output logic [15:0] snapshot,
   output logic        snap_valid,
   output logic        timeout_err,
   output logic        busy,
   output logic [31:0] poll_count
);

   localparam logic [TIMER_WIDTH-1:0] POLL_LOAD    = TIMER_WIDTH'(POLL_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] TIMEOUT_LOAD = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

   reader_state_t          state;
   logic [7:0]             lo_byte;
   logic                   timer_load;
   logic [TIMER_WIDTH-1:0] timer_value;
   logic                   timer_dec;
   logic                   timer_tc;
   logic [15:0]            new_snapshot;
`ifdef LED_READER_CHANGE_ONLY_EN
   logic                   first_done;
`endif

   assign new_snapshot = join_bytes(rd_data, lo_byte);

   led_reader_timer #(
      .WIDTH (TIMER_WIDTH)
   ) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load       (timer_load),
      .load_value (timer_value),
      .dec        (timer_dec),
      .tc         (timer_tc)
   );

   // Arms the shared timer on entry to each wait.
   // REQ cycles load the read timeout. UPDATE and a timeout exit load the poll interval.
   always_comb begin
      timer_load  = 1'b0;
      timer_value = '0;
      timer_dec   = 1'b0;
      case (state)
         ST_REQ_LO, ST_REQ_HI: begin
            timer_load  = 1'b1;
            timer_value = TIMEOUT_LOAD;
         end
         ST_WAIT_LO, ST_WAIT_HI: begin
            if (!rd_valid) begin
               if (timer_tc) begin
                  timer_load  = 1'b1;
                  timer_value = POLL_LOAD;
               end else begin
                  timer_dec = 1'b1;
               end
            end
         end
         ST_UPDATE: begin
            timer_load  = 1'b1;
            timer_value = POLL_LOAD;
         end
         ST_WAIT_POLL: begin
            timer_dec = 1'b1;
         end
         default: begin
            timer_load = 1'b0;
         end
      endcase
   end

   // Main sequencer. Every output is registered alongside the state it belongs to.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         rd_en       <= 1'b0;
         rd_addr     <= 8'h00;
         snapshot    <= 16'h0000;
         snap_valid  <= 1'b0;
         timeout_err <= 1'b0;
         busy        <= 1'b0;
         poll_count  <= 32'd0;
         lo_byte     <= 8'h00;
`ifdef LED_READER_CHANGE_ONLY_EN
         first_done  <= 1'b0;
`endif
      end else begin
         rd_en      <= 1'b0;
         snap_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (enable) begin
                  state   <= ST_REQ_LO;
                  rd_en   <= 1'b1;
                  rd_addr <= LED_LO_ADDR;
                  busy    <= 1'b1;
               end
            end
            ST_REQ_LO: begin
               state <= ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
               if (rd_valid) begin
                  lo_byte <= rd_data;
                  state   <= ST_REQ_HI;
                  rd_en   <= 1'b1;
                  rd_addr <= LED_HI_ADDR;
               end else if (timer_tc) begin
                  timeout_err <= 1'b1;
                  if (enable) begin
                     state <= ST_WAIT_POLL;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            ST_REQ_HI: begin
               state <= ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
               if (rd_valid) begin
                  state      <= ST_UPDATE;
                  snapshot   <= new_snapshot;
                  poll_count <= poll_count + 32'd1;
`ifdef LED_READER_CHANGE_ONLY_EN
                  snap_valid <= !first_done || (new_snapshot != snapshot);
                  first_done <= 1'b1;
`else
                  snap_valid <= 1'b1;
`endif
               end else if (timer_tc) begin
                  timeout_err <= 1'b1;
                  if (enable) begin
                     state <= ST_WAIT_POLL;
                  end else begin
                     state <= ST_IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            ST_UPDATE: begin
               if (enable) begin
                  state <= ST_WAIT_POLL;
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end
            end
            ST_WAIT_POLL: begin
               if (!enable) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
               end else if (timer_tc) begin
                  state   <= ST_REQ_LO;
                  rd_en   <= 1'b1;
                  rd_addr <= LED_LO_ADDR;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_status_reader.sv
// Self-checking bench for led_status_reader.
// A behavioural peripheral answers each read one cycle after rd_en.
// Snapshot vectors come from a table. The latency, timeout, enable-drop, reset
// and change-filter cases are written out as hand sequences.
module tb_led_status_reader;

   logic        clk;
   logic        rst;
   logic        enable;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [7:0]  rd_data;
   logic        rd_valid;
   logic [15:0] snapshot;
   logic        snap_valid;
   logic        timeout_err;
   logic        busy;
   logic [31:0] poll_count;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int snap_pulses = 0;
   int rd_en_pulses = 0;

   logic [7:0] lo_val = 8'h00;
   logic [7:0] hi_val = 8'h00;
   logic       respond_lo = 1'b1;
   logic       respond_hi = 1'b1;
   logic       pend = 1'b0;
   logic [7:0] pend_data = 8'h00;

   typedef struct {
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic [15:0] exp_snap;
   } vec_t;

   vec_t vecs[4];

   led_status_reader #(
      .POLL_CYCLES    (4),
      .TIMEOUT_CYCLES (8),
      .LED_LO_ADDR    (8'h00),
      .LED_HI_ADDR    (8'h01)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .rd_en       (rd_en),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .rd_valid    (rd_valid),
      .snapshot    (snapshot),
      .snap_valid  (snap_valid),
      .timeout_err (timeout_err),
      .busy        (busy),
      .poll_count  (poll_count)
   );

   // 10-time-unit clock with a cycle counter that advances on each rising edge
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   // Counts strobe pulses, sampled on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (snap_valid) snap_pulses++;
         if (rd_en) rd_en_pulses++;
      end
   end

   // Peripheral model: a read seen with rd_en is answered in the following cycle
   initial begin
      rd_valid = 1'b0;
      rd_data  = 8'h00;
      forever begin
         @(posedge clk);
         #1;
         rd_valid = pend;
         rd_data  = pend_data;
         pend     = 1'b0;
         if (rd_en && ((rd_addr == 8'h00 && respond_lo) || (rd_addr == 8'h01 && respond_hi))) begin
            pend      = 1'b1;
            pend_data = (rd_addr == 8'h00) ? lo_val : hi_val;
         end
      end
   end

   // Stops the run outright if the sequence never completes
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic report_expired(input string name);
      tests++;
      fails++;
      $display("[TB] FAIL %s: wait expired (got none, expected an event)", name);
   endtask

   task automatic apply_stimulus(input logic [7:0] lo, input logic [7:0] hi);
      lo_val = lo;
      hi_val = hi;
   endtask

   task automatic wait_rd_en(input string name, output int at_cyc);
      bit found = 0;
      at_cyc = -1;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk);
         if (rd_en) begin
            found  = 1;
            at_cyc = cyc;
         end
      end
      if (!found) report_expired(name);
   endtask

   task automatic wait_snap(input string name, output int at_cyc);
      bit found = 0;
      at_cyc = -1;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk);
         if (snap_valid) begin
            found  = 1;
            at_cyc = cyc;
         end
      end
      if (!found) report_expired(name);
   endtask

   task automatic wait_poll_count(input string name, input logic [31:0] target);
      bit found = 0;
      for (int n = 0; n < 200 && !found; n++) begin
         @(negedge clk);
         if (poll_count == target) found = 1;
      end
      if (!found) report_expired(name);
   endtask

   // Main test sequence
   initial begin
      int c0, c1, c2, ch, cn, prev_req;
      logic [15:0] snap_before;
      logic [31:0] poll_before;
      int pulses_before, rd_before;

      vecs[0] = '{lo: 8'hCD, hi: 8'hAB, exp_snap: 16'hABCD};
      vecs[1] = '{lo: 8'h00, hi: 8'hFF, exp_snap: 16'hFF00};
      vecs[2] = '{lo: 8'hFF, hi: 8'h00, exp_snap: 16'h00FF};
      vecs[3] = '{lo: 8'h5A, hi: 8'hA5, exp_snap: 16'hA55A};

      rst    = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);

      check_output("reset_rd_en", {31'd0, rd_en}, 32'd0);
      check_output("reset_rd_addr", {24'd0, rd_addr}, 32'd0);
      check_output("reset_snapshot", {16'd0, snapshot}, 32'd0);
      check_output("reset_snap_valid", {31'd0, snap_valid}, 32'd0);
      check_output("reset_timeout_err", {31'd0, timeout_err}, 32'd0);
      check_output("reset_busy", {31'd0, busy}, 32'd0);
      check_output("reset_poll_count", poll_count, 32'd0);

      // Basic snapshot with best-case latency
      apply_stimulus(8'h34, 8'h12);
      rst = 1'b1;
      @(negedge clk);
      check_output("idle_busy", {31'd0, busy}, 32'd0);
      enable = 1'b1;
      wait_rd_en("first_lo_req", c0);
      check_output("first_lo_addr", {24'd0, rd_addr}, 32'h00);
      wait_rd_en("first_hi_req", c1);
      check_output("first_hi_addr", {24'd0, rd_addr}, 32'h01);
      check_output("hi_req_spacing", c1 - c0, 32'd2);
      wait_snap("first_snap", c2);
      check_output("snap_latency", c2 - c0, 32'd4);
      check_output("first_snapshot", {16'd0, snapshot}, 32'h1234);
      check_output("first_poll_count", poll_count, 32'd1);
      check_output("update_busy", {31'd0, busy}, 32'd1);
      prev_req = c0;

      // Table-driven polls at the configured interval
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(vecs[i].lo, vecs[i].hi);
         wait_rd_en("table_lo_req", c0);
         check_output("poll_interval", c0 - prev_req, 32'd9);
         prev_req = c0;
         wait_snap("table_snap", c2);
         check_output("table_snapshot", {16'd0, snapshot}, {16'd0, vecs[i].exp_snap});
         check_output("table_poll_count", poll_count, 32'(i + 2));
      end

      // Timeout on the high-byte read
      @(negedge clk);
      snap_before   = snapshot;
      poll_before   = poll_count;
      pulses_before = snap_pulses;
      respond_hi    = 1'b0;
      wait_rd_en("to_lo_req", c0);
      wait_rd_en("to_hi_req", ch);
      check_output("to_hi_addr", {24'd0, rd_addr}, 32'h01);
      repeat (7) @(negedge clk);
      check_output("to_err_before", {31'd0, timeout_err}, 32'd0);
      repeat (2) @(negedge clk);
      check_output("to_err_set", {31'd0, timeout_err}, 32'd1);
      check_output("to_snapshot_kept", {16'd0, snapshot}, {16'd0, snap_before});
      check_output("to_poll_count_kept", poll_count, poll_before);
      check_output("to_no_snap_pulse", snap_pulses - pulses_before, 32'd0);
      respond_hi = 1'b1;
      apply_stimulus(8'h77, 8'h66);
      wait_rd_en("after_to_lo_req", cn);
      check_output("to_retry_timing", cn - ch, 32'd13);
      wait_snap("after_to_snap", c2);
      check_output("after_to_snapshot", {16'd0, snapshot}, 32'h6677);
      check_output("after_to_poll_count", poll_count, poll_before + 32'd1);
      check_output("err_sticky", {31'd0, timeout_err}, 32'd1);

      // Enable dropped during WAIT_LO still completes the transaction
      apply_stimulus(8'h22, 8'h11);
      wait_rd_en("drop_lo_req", c0);
      @(posedge clk);
      #2 enable = 1'b0;
      wait_snap("drop_snap", c2);
      check_output("drop_snapshot", {16'd0, snapshot}, 32'h1122);
      @(negedge clk);
      check_output("drop_busy", {31'd0, busy}, 32'd0);
      rd_before = rd_en_pulses;
      repeat (50) @(negedge clk);
      @(negedge clk);
      check_output("drop_no_rd_en", rd_en_pulses - rd_before, 32'd0);

      // Reset asserted mid-read clears every output immediately
      apply_stimulus(8'h44, 8'h33);
      enable = 1'b1;
      wait_rd_en("rst_lo_req", c0);
      wait_rd_en("rst_hi_req", ch);
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_output("midrst_busy", {31'd0, busy}, 32'd0);
      check_output("midrst_snapshot", {16'd0, snapshot}, 32'd0);
      check_output("midrst_poll_count", poll_count, 32'd0);
      check_output("midrst_timeout_err", {31'd0, timeout_err}, 32'd0);
      check_output("midrst_rd_en", {31'd0, rd_en}, 32'd0);
      repeat (3) @(negedge clk);
      apply_stimulus(8'hEF, 8'hBE);
      pulses_before = snap_pulses;
      rst = 1'b1;
      @(negedge clk);
      check_output("post_rst_rd_en", {31'd0, rd_en}, 32'd1);
      check_output("post_rst_rd_addr", {24'd0, rd_addr}, 32'h00);

      // Change filter: 0xBEEF twice, then 0xBEF0
      wait_poll_count("cf_second", 32'd2);
      apply_stimulus(8'hF0, 8'hBE);
      wait_poll_count("cf_third", 32'd3);
      @(negedge clk);
`ifdef LED_READER_CHANGE_ONLY_EN
      check_output("cf_snap_pulses", snap_pulses - pulses_before, 32'd2);
`else
      check_output("cf_snap_pulses", snap_pulses - pulses_before, 32'd3);
`endif
      check_output("cf_poll_count", poll_count, 32'd3);
      check_output("cf_snapshot", {16'd0, snapshot}, 32'hBEF0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
